user_project_gpio_irq: RTL and testbench

- Input-side stage on the user GPIO path. Sits between the raw io_in pads and the GPIO register block / management core.
- Synchronises all pad inputs and detects per-pin rising and falling edges against enable masks.
- Latches edges as sticky status bits and raises a single level interrupt.
- Exposes enables, status (write-1-to-clear) and synchronised pin levels over a Wishbone slave.

---
 rtl/user_project_gpio_irq_if.sv | 23 ++
 rtl/user_project_gpio_irq.sv | 177 +++++++++++++++++
 tb/tb_user_project_gpio_irq.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_project_gpio_irq_if.sv
// Wishbone slave bundle for the GPIO input/interrupt stage.
// Signal names keep the pad-level Wishbone names so the top-level wiring reads
// the same as the rest of the user project.
interface user_project_gpio_irq_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/user_project_gpio_irq.sv
// GPIO input stage: pad synchroniser, per-pin rise/fall edge detection,
// sticky W1C status and a single level interrupt, all behind a Wishbone slave.
// Optional debounce filter: define GPIO_IRQ_DEBOUNCE_EN.
//
// Register map (word offset = wbs_adr_i[4:2]):
//   0 RISE_LO  1 RISE_HI  2 FALL_LO  3 FALL_HI
//   4 STAT_LO  5 STAT_HI (write-1-to-clear)  6 SYNC_LO  7 SYNC_HI (read-only)
// High words carry pins [NPINS-1:32]; unused bits read 0.
module user_project_gpio_irq #(
    parameter int NPINS   = 38,
    parameter int DEB_DIV = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    user_project_gpio_irq_if.slave wbs,
    input  logic [NPINS-1:0]       io_in,
    output logic [NPINS-1:0]       sync_o,
    output logic                   irq_o
);

    // ------------------------------------------------------------------
    // Pad synchroniser and edge history
    // ------------------------------------------------------------------
    logic [NPINS-1:0] s1_q, s2_q, p_q;
    logic [NPINS-1:0] lvl;      // filtered pin level seen by edge detect

    // Two-flop synchroniser plus the previous-level register for edge detect
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
            p_q  <= '0;
        end else begin
            s1_q <= io_in;
            s2_q <= s1_q;
            p_q  <= lvl;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int CW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    logic [CW-1:0]    cnt_q;
    logic             strobe;
    logic [NPINS-1:0] deb_d_q, deb_q_q;
    logic [NPINS-1:0] deb_same;

    assign strobe   = (cnt_q == CW'(DEB_DIV - 1));
    assign deb_same = ~(deb_d_q ^ s2_q);

    // Free-running sample-strobe divider
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) cnt_q <= '0;
        else            cnt_q <= strobe ? '0 : cnt_q + CW'(1);
    end

    // Accept a new level only when two consecutive strobe samples agree
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            deb_d_q <= '0;
            deb_q_q <= '0;
        end else if (strobe) begin
            deb_d_q <= s2_q;
            deb_q_q <= (deb_same & deb_d_q) | (~deb_same & deb_q_q);
        end
    end

    assign lvl = deb_q_q;
`else
    // Debounce divider is not built; keep the parameter referenced.
    localparam int UNUSED_DEB_DIV = DEB_DIV;
    assign lvl = s2_q;
`endif

    assign sync_o = lvl;

    // ------------------------------------------------------------------
    // Edge detect and sticky status
    // ------------------------------------------------------------------
    logic [NPINS-1:0] rise_en_q, rise_en_d;
    logic [NPINS-1:0] fall_en_q, fall_en_d;
    logic [NPINS-1:0] stat_q, stat_d;
    logic [NPINS-1:0] clr;
    logic [NPINS-1:0] rise, fall;

    assign rise = lvl & ~p_q & rise_en_q;
    assign fall = ~lvl & p_q & fall_en_q;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        access, wr, rd;
    logic        is_hi;
    logic [1:0]  grp;
    logic [31:0] bmask;
    logic [NPINS-1:0] wmask_n, wdat_n;
    logic [63:0] rise64, fall64, stat64, sync64, rsel64;
    logic [31:0] rdata;
    logic        unused_adr;

    // A new access is only taken while ack is low, so a held strobe yields
    // one single-cycle ack per access rather than a stuck-high ack.
    assign access = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
    assign wr     = access & wbs.wbs_we_i;
    assign rd     = access & ~wbs.wbs_we_i;
    assign is_hi  = wbs.wbs_adr_i[2];
    assign grp    = wbs.wbs_adr_i[4:3];

    assign unused_adr = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};

    assign bmask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                    {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};

    // Place the 32-bit lane mask/data onto the low or high pin word;
    // bits beyond NPINS fall off the truncation and are never written.
    assign wmask_n = is_hi ? NPINS'({bmask, 32'b0}) : NPINS'({32'b0, bmask});
    assign wdat_n  = NPINS'({wbs.wbs_dat_i, wbs.wbs_dat_i});

    // Enable writes, W1C clear vector and next status
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr) begin
            case (grp)
                2'd0:    rise_en_d = (rise_en_q & ~wmask_n) | (wdat_n & wmask_n);
                2'd1:    fall_en_d = (fall_en_q & ~wmask_n) | (wdat_n & wmask_n);
                2'd2:    clr       = wdat_n & wmask_n;
                default: ;  // SYNC words are read-only
            endcase
        end
        // New edges are ORed after the clear so a same-cycle event survives
        stat_d = (stat_q & ~clr) | rise | fall;
    end

    assign rise64 = 64'(rise_en_q);
    assign fall64 = 64'(fall_en_q);
    assign stat64 = 64'(stat_q);
    assign sync64 = 64'(lvl);

    // Read mux and handshake next-state
    always_comb begin
        case (grp)
            2'd0:    rsel64 = rise64;
            2'd1:    rsel64 = fall64;
            2'd2:    rsel64 = stat64;
            default: rsel64 = sync64;
        endcase
        rdata = is_hi ? rsel64[63:32] : rsel64[31:0];
        ack_d = access;
        dat_d = rd ? rdata : 32'h0;
    end

    // Enable, status and bus response registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq_o         = |stat_q;

endmodule

// File: tb/tb_user_project_gpio_irq.sv
// Self-checking bench for user_project_gpio_irq. Expected read data is pushed
// to a scoreboard queue before each read and popped when the ack returns.
module tb_user_project_gpio_irq;

    localparam int NP = 38;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int SETTLE = 3 * 16 + 8;
`else
    localparam int SETTLE = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] io_in = '0;
    logic [NP-1:0] sync_o;
    logic          irq_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    user_project_gpio_irq_if bus ();

    user_project_gpio_irq #(.NPINS(NP), .DEB_DIV(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs       (bus),
        .io_in     (io_in),
        .sync_o    (sync_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = 32'h0;
        bus.wbs_adr_i = 32'h0;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel);
        bit ok = 0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = d;
        bus.wbs_adr_i = {27'b0, idx, 2'b0};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin ok = 1; break; end
        end
        bus_idle();
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL write_ack_timeout idx=%0d got no ack, need ack", idx);
        end
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [31:0] d);
        bit ok = 0;
        d = 32'hxxxx_xxxx;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = {27'b0, idx, 2'b0};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin ok = 1; d = bus.wbs_dat_o; break; end
        end
        bus_idle();
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL read_ack_timeout idx=%0d got no ack, need ack", idx);
        end
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        rst_n = 1'b0;
        io_in = '0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({irq_o, bus.wbs_ack_o} !== 2'b00 || sync_o !== '0 || bus.wbs_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got irq=%b ack=%b sync=%h dat=%h, need all 0",
                     irq_o, bus.wbs_ack_o, sync_o, bus.wbs_dat_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        for (int i = 0; i < 2; i++) begin
            bus_read(i == 0 ? 3'd0 : 3'd4, got);
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_reg%0d got %h need %h", i, got, e);
            end
        end
    endtask

    task automatic test_rise();
        logic [31:0] got, e;
        bus_write(3'd0, 32'h1, 4'hF);
        io_in[0] = 1'b1;
`ifndef GPIO_IRQ_DEBOUNCE_EN
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_early got irq=%b need 0", irq_o);
        end
        @(posedge clk); #1;
        n_tests++;
        if (irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_latency got irq=%b need 1", irq_o);
        end
`else
        repeat (SETTLE) @(posedge clk);
        #1;
`endif
        for (int i = 0; i < 6; i++) begin
            io_in[1] = ~io_in[1];
            @(posedge clk); #1;
        end
        io_in[1] = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        exp_q.push_back(32'h1);
        bus_read(3'd4, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL rise_stat got %h need %h", got, e);
        end
        bus_write(3'd4, 32'h1, 4'hF);
        exp_q.push_back(32'h0);
        bus_read(3'd4, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_clear got stat=%h irq=%b need %h irq=0", got, irq_o, e);
        end
    endtask

    task automatic test_fall_hi();
        logic [31:0] got, e;
        bus_write(3'd3, 32'h20, 4'hF);
        io_in[37] = 1'b1;
        repeat (SETTLE) @(posedge clk);
        io_in[37] = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h0);
        bus_read(3'd5, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e || irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_hi_stat got %h irq=%b need %h irq=1", got, irq_o, e);
        end
        bus_read(3'd4, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL fall_hi_lo_clean got %h need %h", got, e);
        end
        bus_write(3'd5, 32'h20, 4'hF);
        exp_q.push_back(32'h0);
        bus_read(3'd5, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_hi_clear got %h irq=%b need %h irq=0", got, irq_o, e);
        end
    endtask

`ifndef GPIO_IRQ_DEBOUNCE_EN
    task automatic test_same_cycle();
        logic [31:0] got, e;
        io_in[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        // Edge arrives at status two edges after the synchroniser samples it;
        // the write below completes on exactly that edge.
        io_in[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_write(3'd4, 32'h1, 4'hF);
        exp_q.push_back(32'h1);
        bus_read(3'd4, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL same_cycle_set_wins got %h need %h", got, e);
        end
        bus_write(3'd4, 32'h1, 4'hF);
        exp_q.push_back(32'h0);
        bus_read(3'd4, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL same_cycle_clear got %h need %h", got, e);
        end
    endtask
`endif

    task automatic test_byte_lane();
        logic [31:0] got, e;
        bit ok = 0;
        bus_write(3'd0, 32'h0, 4'hF);
        bus_write(3'd0, 32'hFFFF_FFFF, 4'b0100);
        exp_q.push_back(32'h00FF_0000);
        bus_read(3'd0, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL byte_lane got %h need %h", got, e);
        end
        // Held strobe: one-cycle ack with data, then ack and data drop
        exp_q.push_back(32'h00FF_0000);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'h0;
        got = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin ok = 1; got = bus.wbs_dat_o; break; end
        end
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || got !== e) begin
            n_fail++;
            $display("FAIL held_stb_first got ack=%b dat=%h need ack=1 dat=%h", ok, got, e);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL held_stb_drop got ack=%b dat=%h need ack=0 dat=0",
                     bus.wbs_ack_o, bus.wbs_dat_o);
        end
        bus_idle();
        bus_write(3'd0, 32'h0, 4'hF);
    endtask

    task automatic test_sync();
        logic [31:0] got, e;
        logic [NP-1:0] prev, pat;
        pat  = 38'h2A_DEAD_BEEF;
        prev = io_in;
        io_in = pat;
`ifndef GPIO_IRQ_DEBOUNCE_EN
        @(posedge clk); #1;
        n_tests++;
        if (sync_o !== prev) begin
            n_fail++;
            $display("FAIL sync_one_edge got %h need %h", sync_o, prev);
        end
        @(posedge clk); #1;
        n_tests++;
        if (sync_o !== pat) begin
            n_fail++;
            $display("FAIL sync_two_edges got %h need %h", sync_o, pat);
        end
`else
        repeat (SETTLE) @(posedge clk);
        #1;
`endif
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'h0000_002A);
        exp_q.push_back(32'hDEAD_BEEF);
        bus_read(3'd6, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL sync_lo got %h need %h", got, e);
        end
        bus_read(3'd7, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL sync_hi got %h need %h", got, e);
        end
        bus_write(3'd6, 32'h0, 4'hF);
        bus_read(3'd6, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL sync_ro_write got %h need %h", got, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, e;
        int acks = 0;
        bus_write(3'd1, 32'h3F, 4'hF);
        bus_write(3'd2, 32'h5, 4'hF);
        io_in = '0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = {27'b0, 3'd6, 2'b0};
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o !== 1'b0) acks++;
        end
        bus_idle();
        rst_n = 1'b1;
        n_tests++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_mid_ack got %0d acks need 0", acks);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), got);
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid_reg%0d got %h need %h", i, got, e);
            end
        end
        n_tests++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_irq got %b need 0", irq_o);
        end
    endtask

`ifdef GPIO_IRQ_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] got, e;
        bus_write(3'd0, 32'h4, 4'hF);
        io_in[2] = 1'b1;
        repeat (5) @(posedge clk);
        io_in[2] = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        bus_read(3'd4, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL debounce_short got %h need %h", got, e);
        end
        io_in[2] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        exp_q.push_back(32'h4);
        bus_read(3'd4, got);
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL debounce_long got %h need %h", got, e);
        end
    endtask
`endif

    initial begin
        bus_idle();
        test_reset();
        test_rise();
        test_fall_hi();
`ifndef GPIO_IRQ_DEBOUNCE_EN
        test_same_cycle();
`endif
        test_byte_lane();
        test_sync();
        test_reset_mid();
`ifdef GPIO_IRQ_DEBOUNCE_EN
        test_debounce();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
